// File: rtl/fetch_controller.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch, redirect/stall/halt control.
// Ports: Clk/Reset; ReadAddress/Instruction to instruction memory; Stall, BranchTaken/
// BranchTarget, Jump/JumpIndex from ID; IFID_* latch to decode; Halted; Fetch/Bubble counters.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] ReadAddress,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HALTED   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        pc_in_range;
  logic [31:0] pc_plus4;

  assign redirect = BranchTaken | Jump;

  // Branch wins over jump when both resolve in the same cycle.
  assign redirect_pc = BranchTaken ? {BranchTarget[31:2], 2'b00}
                                   : {ifid_pc4_q[31:28], JumpIndex, 2'b00};

  // Word index compared zero-extended so any PC above the memory is out of range.
  assign pc_in_range = ({2'b00, pc_q[31:2]} < 32'(MEM_WORDS));
  assign pc_plus4    = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_vld_d   = ifid_vld_q;
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (redirect) begin
      // Redirect is honoured in every state and always flushes IF/ID.
      pc_d         = redirect_pc;
      ifid_instr_d = 32'h0;
      ifid_pc4_d   = 32'h0;
      ifid_vld_d   = 1'b0;
      state_d      = ST_REDIRECT;
      // Cycles spent halted are not bubbles.
      if (state_q != ST_HALTED) begin
        bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
    end else begin
      unique case (state_q)
        ST_RUN, ST_REDIRECT: begin
          if (Stall) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
          end else if (pc_in_range) begin
            pc_d         = pc_plus4;
            ifid_instr_d = Instruction;
            ifid_pc4_d   = pc_plus4;
            ifid_vld_d   = 1'b1;
            fetch_cnt_d  = fetch_cnt_q + 32'd1;
            state_d      = ST_RUN;
          end else begin
            // Ran off the end of memory: park the PC and present a bubble.
            ifid_instr_d = 32'h0;
            ifid_pc4_d   = 32'h0;
            ifid_vld_d   = 1'b0;
            state_d      = ST_HALTED;
          end
        end
        ST_HALTED: begin
          // Stall is irrelevant here; everything holds until a redirect or reset.
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      ifid_instr_q <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_vld_q   <= 1'b0;
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_vld_q   <= ifid_vld_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ReadAddress      = pc_q;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PCPlus4     = ifid_pc4_q;
  assign IFID_Valid       = ifid_vld_q;
  assign Halted           = (state_q == ST_HALTED);
  assign FetchCount       = fetch_cnt_q;
  assign BubbleCount      = bubble_cnt_q;

endmodule
